// File: rtl/ofmap_bit_packer.sv
// Packs 1-bit binarized activations into WORD_WIDTH-bit masked BRAM writes and signals layer completion.
// Optional: define PACKER_EARLY_FLUSH_EN to write a word as soon as all of its bits are captured.
module ofmap_bit_packer #(
  parameter int OFMAPS_BRAM_ADDR_WIDTH = 12,
  parameter int WORD_WIDTH             = 32
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              i_data,
  input  logic [OFMAPS_BRAM_ADDR_WIDTH-1:0]                 i_addr,
  input  logic                                              i_valid,
  input  logic                                              i_last,
  output logic                                              bram_we,
  output logic [OFMAPS_BRAM_ADDR_WIDTH-$clog2(WORD_WIDTH)-1:0] bram_addr,
  output logic [WORD_WIDTH-1:0]                             bram_wdata,
  output logic [WORD_WIDTH-1:0]                             bram_wmask,
  output logic                                              o_done,
  output logic [OFMAPS_BRAM_ADDR_WIDTH-$clog2(WORD_WIDTH):0] o_word_count
);

  localparam int IDX_W   = $clog2(WORD_WIDTH);
  localparam int WADDR_W = OFMAPS_BRAM_ADDR_WIDTH - IDX_W;

`ifdef PACKER_EARLY_FLUSH_EN
  localparam bit EARLY_FLUSH = 1'b1;
`else
  localparam bit EARLY_FLUSH = 1'b0;
`endif

  typedef enum logic {IDLE, ACC} state_t;

  state_t                 state, state_n;
  logic [WADDR_W-1:0]     pend_addr, pend_addr_n;
  logic [WORD_WIDTH-1:0]  pend_data, pend_data_n;
  logic [WORD_WIDTH-1:0]  pend_mask, pend_mask_n;
  logic                   done_pend, done_pend_n;

  logic                   we_n, done_n;
  logic [WADDR_W-1:0]     addr_n;
  logic [WORD_WIDTH-1:0]  wdata_n, wmask_n;
  logic [WADDR_W:0]       count_n;

  logic [WADDR_W-1:0]     in_waddr;
  logic [IDX_W-1:0]       in_idx;
  logic [WORD_WIDTH-1:0]  onehot, new_data, merged_mask, merged_data;
  logic                   have, same;

  assign in_waddr = i_addr[OFMAPS_BRAM_ADDR_WIDTH-1:IDX_W];
  assign in_idx   = i_addr[IDX_W-1:0];
  assign onehot   = {{(WORD_WIDTH-1){1'b0}}, 1'b1} << in_idx;
  assign new_data = i_data ? onehot : '0;
  assign have     = (state == ACC);
  assign same     = have && (in_waddr == pend_addr);

  // Fold the incoming bit into the open word (or an empty one when nothing is open).
  assign merged_mask = (same ? pend_mask : '0) | onehot;
  assign merged_data = ((same ? pend_data : '0) & ~onehot) | new_data;

  always_comb begin
    state_n     = state;
    pend_addr_n = pend_addr;
    pend_data_n = pend_data;
    pend_mask_n = pend_mask;
    done_pend_n = 1'b0;
    we_n        = 1'b0;
    addr_n      = '0;
    wdata_n     = '0;
    wmask_n     = '0;
    done_n      = 1'b0;

    if (done_pend) begin
      // Second half of a split layer end: the leftover word closes the layer.
      we_n    = 1'b1;
      addr_n  = pend_addr;
      wdata_n = pend_data;
      wmask_n = pend_mask;
      done_n  = 1'b1;
      if (i_valid) begin
        pend_addr_n = in_waddr;
        pend_data_n = new_data;
        pend_mask_n = onehot;
        state_n     = ACC;
      end else begin
        pend_addr_n = '0;
        pend_data_n = '0;
        pend_mask_n = '0;
        state_n     = IDLE;
      end
    end else if (i_valid && have && !same) begin
      we_n        = 1'b1;
      addr_n      = pend_addr;
      wdata_n     = pend_data;
      wmask_n     = pend_mask;
      pend_addr_n = in_waddr;
      pend_data_n = new_data;
      pend_mask_n = onehot;
      state_n     = ACC;
      done_pend_n = i_last;
    end else if (i_valid) begin
      if (i_last || (EARLY_FLUSH && (&merged_mask))) begin
        we_n        = 1'b1;
        addr_n      = in_waddr;
        wdata_n     = merged_data;
        wmask_n     = merged_mask;
        done_n      = i_last;
        pend_addr_n = '0;
        pend_data_n = '0;
        pend_mask_n = '0;
        state_n     = IDLE;
      end else begin
        pend_addr_n = in_waddr;
        pend_data_n = merged_data;
        pend_mask_n = merged_mask;
        state_n     = ACC;
      end
    end else if (i_last) begin
      we_n        = have;
      addr_n      = have ? pend_addr : '0;
      wdata_n     = have ? pend_data : '0;
      wmask_n     = have ? pend_mask : '0;
      done_n      = 1'b1;
      pend_addr_n = '0;
      pend_data_n = '0;
      pend_mask_n = '0;
      state_n     = IDLE;
    end
  end

  // The count restarts for the next layer on the cycle after o_done.
  assign count_n = (o_done ? '0 : o_word_count) + {{WADDR_W{1'b0}}, we_n};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pend_addr    <= '0;
      pend_data    <= '0;
      pend_mask    <= '0;
      done_pend    <= 1'b0;
      bram_we      <= 1'b0;
      bram_addr    <= '0;
      bram_wdata   <= '0;
      bram_wmask   <= '0;
      o_done       <= 1'b0;
      o_word_count <= '0;
    end else begin
      state        <= state_n;
      pend_addr    <= pend_addr_n;
      pend_data    <= pend_data_n;
      pend_mask    <= pend_mask_n;
      done_pend    <= done_pend_n;
      bram_we      <= we_n;
      bram_addr    <= addr_n;
      bram_wdata   <= wdata_n;
      bram_wmask   <= wmask_n;
      o_done       <= done_n;
      o_word_count <= count_n;
    end
  end

endmodule

// File: doc/ofmap_bit_packer.md
# ofmap_bit_packer

Packs the 1-bit binarized activations from the psum adder/comparator stage into WORD_WIDTH-bit words and issues masked writes to the ofmaps BRAM. It sits directly downstream of the psum adder. It consumes that stage's data bit, bit address, valid and layer-finish outputs, and drives the BRAM write port. It also reports the completion of each layer to the layer controller.

## Interface
- OFMAPS_BRAM_ADDR_WIDTH, 12, width of incoming bit address (same as psum adder address_out)
- WORD_WIDTH, 32, BRAM data width in bits; power of two, 8..64
- IDX_W (localparam), $clog2(WORD_WIDTH), bit index width
- WADDR_W (localparam), OFMAPS_BRAM_ADDR_WIDTH-IDX_W, BRAM word address width

- clk  in  1  single clock; all logic posedge
- rst_n  in  1  asynchronous, active-low reset
- i_data  in  1  activation bit
- i_addr  in  OFMAPS_BRAM_ADDR_WIDTH  bit address; word = i_addr[MSB:IDX_W], index = i_addr[IDX_W-1:0]
- i_valid  in  1  i_data/i_addr valid this cycle
- i_last  in  1  layer-finish pulse, independent of i_valid
- bram_we  out  1  write strobe, one cycle per word
- bram_addr  out  WADDR_W  word address
- bram_wdata  out  WORD_WIDTH  packed bits; unwritten positions 0
- bram_wmask  out  WORD_WIDTH  per-bit write enable, 1 = bit captured
- o_done  out  1  one-cycle pulse: layer flushed
- o_word_count  out  WADDR_W+1  words written since last o_done; wraps

## Operation
- Holding state: pend_addr (WADDR_W), pend_data and pend_mask (WORD_WIDTH each), count register.
- FSM has two states: IDLE (no pending bits) and ACC (pending word open).
- IDLE + i_valid:
  - Open the word at i_addr's word address.
  - Set that word's mask bit and data bit.
  - Go to ACC.
- ACC + i_valid, same word address: set the mask/data bit at the index. A repeated index overwrites the data bit; the mask stays 1.
- ACC + i_valid, different word address:
  - Flush the pending word (bram_we next cycle).
  - Open the new word with only the new bit.
  - Stay in ACC.
- i_last (any state):
  - Fold any same-cycle i_valid into the pending word first.
  - If the result is different-address, flush the old word and discard nothing. The new bit becomes a second pending word. That word is written one cycle later, and o_done is delayed accordingly.
  - Then flush the pending word, if any.
  - Return to IDLE.
- Flush: drive bram_addr=pend_addr, bram_wdata=pend_data, bram_wmask=pend_mask. Increment o_word_count.
- o_done pulses in the same cycle as the final flush write, or alone if nothing was pending. o_word_count clears to 0 on the cycle after o_done.
- A word is never written with a zero mask.

## Timing
- Reset values: bram_we=0, bram_addr=0, bram_wdata=0, bram_wmask=0, o_done=0, o_word_count=0. FSM in IDLE; pending bits cleared.
- Reset mid-operation discards pending bits; no write occurs.
- All outputs are registered.
- Flush triggered at cycle t → bram_we high at t+1 only.
- i_last at t, no split → final write (if any) and o_done at t+1.
- i_last at t with a different-address i_valid → old word written at t+1; new word written and o_done at t+2.
- Input throughput is one bit per cycle with no stall. The BRAM write port always accepts.
- i_valid during the o_done cycle opens a new layer's word normally.

## Configuration
- PACKER_EARLY_FLUSH_EN defined:
  - When pend_mask becomes all ones at cycle t, the word is written at t+1.
  - The FSM returns to IDLE.
  - A later bit to the same word address opens a fresh word with a single-bit mask.
- Undefined: a full word stays pending until an address change or i_last.

## Test plan
- Sequential fill: 32 bits at addresses 0..31, data alternating 1,0 from address 0, then 1 bit at address 32 → one write with bram_addr=0, wdata=0x55555555, wmask=0xFFFFFFFF when address 32 arrives. With EARLY_FLUSH_EN, the write occurs one cycle after address 31 instead.
- Partial word + last: bits 1 at addresses 64, 66, 67, then i_last → bram_addr=2, wdata=0x0000000D, wmask=0x0000000D; o_done on the same cycle; o_word_count=1, then 0.
- Simultaneous valid+last, different word: addr 5 (data 1), then addr 40 (data 1) together with i_last → write addr 0 mask 0x20 at t+1; write addr 1 mask 0x100 plus o_done at t+2.
- Empty layer: i_last with no valid → o_done at t+1; bram_we stays 0.
- Reset mid-word: 10 bits into word 3, assert rst_n low → all outputs 0. After release, i_last → o_done with no write.
- Overwrite: addr 7 data 1, then addr 7 data 0, then i_last → wdata=0x0, wmask=0x80.
